// File: rtl/mem_refill_ctrl.sv
// Miss handler: writes back a dirty victim line, then fills the missing line over a valid/ready bus.
// Latency: 3 cycles from the miss edge to the response pulse (BEATS=1, clean), plus BEATS cycles for a write-back.
// Backpressure: commands hold valid/addr/we/wdata stable until ready; read beats cannot be stalled.
module mem_refill_ctrl #(
    parameter int LINE_W = 32,
    parameter int BUS_W  = 32,
    parameter int ADDR_W = 32,
    parameter int OFFS_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cache_miss,
    input  logic [ADDR_W-1:0] miss_addr,
    input  logic              evict,
    input  logic [ADDR_W-1:0] evict_addr,
    input  logic [LINE_W-1:0] evict_data,
    output logic [LINE_W-1:0] o_memory_line,
    output logic              o_memory_response,
    output logic              busy,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [BUS_W-1:0]  mem_req_wdata,
    input  logic              mem_rsp_valid,
    input  logic [BUS_W-1:0]  mem_rsp_data
);

    localparam int BEATS  = LINE_W / BUS_W;
    localparam int STRIDE = BUS_W / 8;
    localparam int KW     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [KW-1:0]     LAST_BEAT = KW'(BEATS - 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFFS_W){1'b1}}, {OFFS_W{1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        WB,
        FILL_REQ,
        FILL_DATA,
        RESP,
        HOLD
    } state_t;

    state_t            state;
    logic [KW-1:0]     beat;
    logic [ADDR_W-1:0] miss_base;
    logic [ADDR_W-1:0] evict_base;
    logic [LINE_W-1:0] evict_line;

    // Next write-back beat: address and data slice one step past the current beat.
    logic [KW-1:0]     beat_nxt;
    logic [ADDR_W-1:0] wb_addr_nxt;
    logic [LINE_W-1:0] wb_shift;
    logic [BUS_W-1:0]  wb_data_nxt;

    assign beat_nxt    = beat + KW'(1);
    assign wb_addr_nxt = evict_base + ADDR_W'(beat_nxt) * ADDR_W'(STRIDE);
    assign wb_shift    = evict_line >> (BUS_W * int'(beat_nxt));
    assign wb_data_nxt = wb_shift[BUS_W-1:0];

    // Busy is a pure decode of the registered state.
    assign busy = (state != IDLE);

    // Refill FSM; command outputs are registered and loaded one cycle ahead of their use.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= IDLE;
            beat              <= '0;
            miss_base         <= '0;
            evict_base        <= '0;
            evict_line        <= '0;
            o_memory_line     <= '0;
            o_memory_response <= 1'b0;
            mem_req_valid     <= 1'b0;
            mem_req_we        <= 1'b0;
            mem_req_addr      <= '0;
            mem_req_wdata     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cache_miss) begin
                        miss_base     <= miss_addr & LINE_MASK;
                        evict_base    <= evict_addr & LINE_MASK;
                        evict_line    <= evict_data;
                        beat          <= '0;
                        mem_req_valid <= 1'b1;
                        if (evict) begin
                            state         <= WB;
                            mem_req_we    <= 1'b1;
                            mem_req_addr  <= evict_addr & LINE_MASK;
                            mem_req_wdata <= evict_data[BUS_W-1:0];
                        end else begin
                            state         <= FILL_REQ;
                            mem_req_we    <= 1'b0;
                            mem_req_addr  <= miss_addr & LINE_MASK;
                            mem_req_wdata <= '0;
                        end
                    end
                end
                WB: begin
                    if (mem_req_ready) begin
                        if (beat == LAST_BEAT) begin
                            // Chain straight into the line read with no valid bubble.
                            state         <= FILL_REQ;
                            mem_req_we    <= 1'b0;
                            mem_req_addr  <= miss_base;
                            mem_req_wdata <= '0;
                        end else begin
                            beat          <= beat_nxt;
                            mem_req_addr  <= wb_addr_nxt;
                            mem_req_wdata <= wb_data_nxt;
                        end
                    end
                end
                FILL_REQ: begin
                    if (mem_req_ready) begin
                        state         <= FILL_DATA;
                        beat          <= '0;
                        mem_req_valid <= 1'b0;
                        mem_req_we    <= 1'b0;
                        mem_req_addr  <= '0;
                        mem_req_wdata <= '0;
                    end
                end
                FILL_DATA: begin
                    if (mem_rsp_valid) begin
                        o_memory_line[int'(beat)*BUS_W +: BUS_W] <= mem_rsp_data;
                        if (beat == LAST_BEAT) begin
                            state             <= RESP;
                            o_memory_response <= 1'b1;
                        end else begin
                            beat <= beat_nxt;
                        end
                    end
                end
                RESP: begin
                    o_memory_response <= 1'b0;
                    state             <= HOLD;
                end
                HOLD: begin
                    // sa_cache still shows the old miss here; let it install the line first.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_refill_ctrl.sv
// Scoreboard bench for mem_refill_ctrl: a 32-bit-bus instance and an 8-bit-bus (4-beat) instance.
// Latency: checked against the 3-cycle clean / +BEATS dirty figures.
// Backpressure: ready is stalled on the wide instance; read beats are never stalled.
module tb_mem_refill_ctrl;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
    } cmd_t;

    logic core_clk = 1'b0;
    logic rst      = 1'b0;
    always #5 core_clk = ~core_clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge core_clk) cyc <= cyc + 1;

    // DUT A: BUS_W=32, one beat per line
    logic        miss_a = 0, ev_a = 0, rr_a = 1, rspv_a = 0;
    logic [31:0] maddr_a = 0, eaddr_a = 0, edata_a = 0, rspd_a = 0;
    logic [31:0] line_a, ra_a, wd_a;
    logic        resp_a, busy_a, rv_a, we_a;

    // DUT B: BUS_W=8, four beats per line
    logic        miss_b = 0, ev_b = 0, rr_b = 1, rspv_b = 0;
    logic [31:0] maddr_b = 0, eaddr_b = 0, edata_b = 0, ra_b, line_b;
    logic [7:0]  rspd_b = 0, wd_b;
    logic        resp_b, busy_b, rv_b, we_b;

    mem_refill_ctrl #(.LINE_W(32), .BUS_W(32), .ADDR_W(32), .OFFS_W(6)) u_dut_a (
        .clk(core_clk), .rst(rst), .cache_miss(miss_a), .miss_addr(maddr_a),
        .evict(ev_a), .evict_addr(eaddr_a), .evict_data(edata_a),
        .o_memory_line(line_a), .o_memory_response(resp_a), .busy(busy_a),
        .mem_req_valid(rv_a), .mem_req_ready(rr_a), .mem_req_we(we_a),
        .mem_req_addr(ra_a), .mem_req_wdata(wd_a),
        .mem_rsp_valid(rspv_a), .mem_rsp_data(rspd_a)
    );

    mem_refill_ctrl #(.LINE_W(32), .BUS_W(8), .ADDR_W(32), .OFFS_W(6)) u_dut_b (
        .clk(core_clk), .rst(rst), .cache_miss(miss_b), .miss_addr(maddr_b),
        .evict(ev_b), .evict_addr(eaddr_b), .evict_data(edata_b),
        .o_memory_line(line_b), .o_memory_response(resp_b), .busy(busy_b),
        .mem_req_valid(rv_b), .mem_req_ready(rr_b), .mem_req_we(we_b),
        .mem_req_addr(ra_b), .mem_req_wdata(wd_b),
        .mem_rsp_valid(rspv_b), .mem_rsp_data(rspd_b)
    );

    cmd_t        exp_cmd_a[$], exp_cmd_b[$];
    logic [31:0] exp_line_a[$], exp_line_b[$];
    logic [31:0] rd_a[$];
    logic [7:0]  rd_b[$];

    int cmd_cnt_a = 0, cmd_cnt_b = 0, last_cmd_cyc_a = 0;
    int fill_req_a = 0, fill_req_b = 0;
    int resp_cnt_a = 0, resp_cnt_b = 0, resp_cyc_a = 0, resp_cyc_b = 0;
    logic resp_prev_a = 0, resp_prev_b = 0;
    int stray_req_a = 0;
    logic [31:0] stray_dat_a = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor for A, sampled mid-cycle: the handshake seen here completes at the next edge.
    always @(negedge core_clk) begin
        if (rst) begin
            if (rv_a && rr_a) begin
                cmd_cnt_a++;
                last_cmd_cyc_a = cyc;
                if (exp_cmd_a.size() == 0) begin
                    check("cmd_unexpected_a", 64'(ra_a), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    cmd_t e;
                    e = exp_cmd_a.pop_front();
                    check("cmd_we_a", 64'(we_a), 64'(e.we));
                    check("cmd_addr_a", 64'(ra_a), 64'(e.addr));
                    check("cmd_wdata_a", 64'(wd_a), 64'(e.wd));
                end
                if (!we_a) fill_req_a++;
            end
            if (resp_a) begin
                resp_cnt_a++;
                resp_cyc_a = cyc;
                check("resp_pulse_a", 64'(resp_prev_a), 64'd0);
                if (exp_line_a.size() == 0) check("resp_unexpected_a", 64'd1, 64'd0);
                else check("line_a", 64'(line_a), 64'(exp_line_a.pop_front()));
            end
        end
        resp_prev_a = resp_a;
    end

    // Scoreboard monitor for B.
    always @(negedge core_clk) begin
        if (rst) begin
            if (rv_b && rr_b) begin
                cmd_cnt_b++;
                if (exp_cmd_b.size() == 0) begin
                    check("cmd_unexpected_b", 64'(ra_b), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    cmd_t e;
                    e = exp_cmd_b.pop_front();
                    check("cmd_we_b", 64'(we_b), 64'(e.we));
                    check("cmd_addr_b", 64'(ra_b), 64'(e.addr));
                    check("cmd_wdata_b", 64'(wd_b), 64'(e.wd));
                end
                if (!we_b) fill_req_b++;
            end
            if (resp_b) begin
                resp_cnt_b++;
                resp_cyc_b = cyc;
                check("resp_pulse_b", 64'(resp_prev_b), 64'd0);
                if (exp_line_b.size() == 0) check("resp_unexpected_b", 64'd1, 64'd0);
                else check("line_b", 64'(line_b), 64'(exp_line_b.pop_front()));
            end
        end
        resp_prev_b = resp_b;
    end

    // Memory responders: read beats start the cycle after the read command is accepted.
    initial begin
        int served = 0, left = 0, stray_done = 0;
        forever begin
            @(posedge core_clk); #1;
            if (fill_req_a != served) begin served++; left = 1; end
            if (left > 0) begin
                rspv_a = 1'b1;
                rspd_a = (rd_a.size() != 0) ? rd_a.pop_front() : 32'h0;
                left--;
            end else if (stray_req_a != stray_done) begin
                stray_done++;
                rspv_a = 1'b1;
                rspd_a = stray_dat_a;
            end else begin
                rspv_a = 1'b0;
            end
        end
    end

    initial begin
        int served = 0, left = 0;
        forever begin
            @(posedge core_clk); #1;
            if (fill_req_b != served) begin served++; left = 4; end
            if (left > 0) begin
                rspv_b = 1'b1;
                rspd_b = (rd_b.size() != 0) ? rd_b.pop_front() : 8'h0;
                left--;
            end else begin
                rspv_b = 1'b0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge core_clk); #1; end
    endtask

    // Present a one-cycle miss, then scramble the sampled inputs to prove they were captured.
    task automatic start_miss(input bit b, input logic [31:0] ma, input logic e,
                              input logic [31:0] ea, input logic [31:0] ed);
        if (b) begin maddr_b = ma; ev_b = e; eaddr_b = ea; edata_b = ed; miss_b = 1'b1; end
        else   begin maddr_a = ma; ev_a = e; eaddr_a = ea; edata_a = ed; miss_a = 1'b1; end
        tick(1);
        if (b) begin miss_b = 1'b0; maddr_b = '1; ev_b = ~e; eaddr_b = '1; edata_b = '0; end
        else   begin miss_a = 1'b0; maddr_a = '1; ev_a = ~e; eaddr_a = '1; edata_a = '0; end
    endtask

    task automatic wait_resp(input bit b, input int limit);
        int s, t;
        s = b ? resp_cnt_b : resp_cnt_a;
        t = 0;
        while (((b ? resp_cnt_b : resp_cnt_a) == s) && (t < limit)) begin tick(1); t++; end
        if ((b ? resp_cnt_b : resp_cnt_a) == s) check(b ? "resp_timeout_b" : "resp_timeout_a", 64'd0, 64'd1);
    endtask

    initial begin
        int c, r, n;
        tick(2);
        check("rst_line_a", 64'(line_a), 64'd0);
        check("rst_resp_a", 64'(resp_a), 64'd0);
        check("rst_busy_a", 64'(busy_a), 64'd0);
        check("rst_valid_a", 64'(rv_a), 64'd0);
        check("rst_line_b", 64'(line_b), 64'd0);
        check("rst_busy_b", 64'(busy_b), 64'd0);
        rst = 1'b1;
        tick(2);

        // 1: clean miss, single beat
        exp_cmd_a.push_back('{1'b0, 32'h0000_0040, 32'h0});
        rd_a.push_back(32'hDEAD_BEEF);
        exp_line_a.push_back(32'hDEAD_BEEF);
        c = cyc;
        start_miss(1'b0, 32'h0000_0044, 1'b0, 32'h0, 32'h0);
        wait_resp(1'b0, 20);
        check("lat_clean", 64'(resp_cyc_a - c), 64'd3);
        tick(2);
        check("idle_busy", 64'(busy_a), 64'd0);
        check("idle_valid", 64'(rv_a), 64'd0);
        check("idle_we", 64'(we_a), 64'd0);
        check("idle_addr", 64'(ra_a), 64'd0);
        check("idle_line_hold", 64'(line_a), 64'hDEAD_BEEF);

        // 2: dirty miss, write-back then fill
        exp_cmd_a.push_back('{1'b1, 32'h0004_0000, 32'hCAFE_F00D});
        exp_cmd_a.push_back('{1'b0, 32'h0000_1000, 32'h0});
        rd_a.push_back(32'h5A5A_1234);
        exp_line_a.push_back(32'h5A5A_1234);
        c = cyc;
        start_miss(1'b0, 32'h0000_1000, 1'b1, 32'h0004_0010, 32'hCAFE_F00D);
        wait_resp(1'b0, 20);
        check("lat_dirty", 64'(resp_cyc_a - c), 64'd4);
        tick(2);

        // 3: fill command backpressure
        rr_a = 1'b0;
        n = cmd_cnt_a;
        exp_cmd_a.push_back('{1'b0, 32'h0000_2080, 32'h0});
        rd_a.push_back(32'h0BAD_CAFE);
        exp_line_a.push_back(32'h0BAD_CAFE);
        start_miss(1'b0, 32'h0000_20A7, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 64'(rv_a), 64'd1);
            check("bp_addr", 64'(ra_a), 64'h0000_2080);
            check("bp_we", 64'(we_a), 64'd0);
            check("bp_busy", 64'(busy_a), 64'd1);
            tick(1);
        end
        rr_a = 1'b1;
        wait_resp(1'b0, 20);
        check("bp_one_cmd", 64'(cmd_cnt_a - n), 64'd1);
        tick(2);

        // 5: miss held high across the response, second miss waits out HOLD
        exp_cmd_a.push_back('{1'b0, 32'h0000_3000, 32'h0});
        exp_cmd_a.push_back('{1'b0, 32'h0000_3400, 32'h0});
        rd_a.push_back(32'h1111_1111);
        rd_a.push_back(32'h2222_2222);
        exp_line_a.push_back(32'h1111_1111);
        exp_line_a.push_back(32'h2222_2222);
        maddr_a = 32'h0000_3000; ev_a = 1'b0; miss_a = 1'b1;
        tick(1);
        maddr_a = 32'h0000_3400;
        wait_resp(1'b0, 20);
        r = resp_cyc_a;
        check("hold_busy", 64'(busy_a), 64'd1);
        check("hold_valid", 64'(rv_a), 64'd0);
        tick(1);
        check("idle_after_hold", 64'(busy_a), 64'd0);
        tick(1);
        miss_a = 1'b0;
        wait_resp(1'b0, 20);
        check("second_cmd_cycle", 64'(last_cmd_cyc_a - r), 64'd3);
        tick(2);
        stray_dat_a = 32'hBADB_AD00;
        stray_req_a++;
        tick(3);
        check("stray_rsp_ignored", 64'(line_a), 64'h2222_2222);

        // 4: 8-bit bus, four-beat write-back and fill
        for (int i = 0; i < 4; i++) exp_cmd_b.push_back('{1'b1, 32'h0000_3000 + 32'(i), 32'(8'h11 * (i + 1))});
        exp_cmd_b.push_back('{1'b0, 32'h0000_0200, 32'h0});
        rd_b.push_back(8'hA1); rd_b.push_back(8'hB2); rd_b.push_back(8'hC3); rd_b.push_back(8'hD4);
        exp_line_b.push_back(32'hD4C3_B2A1);
        c = cyc;
        start_miss(1'b1, 32'h0000_0215, 1'b1, 32'h0000_3021, 32'h4433_2211);
        wait_resp(1'b1, 40);
        check("lat_b4", 64'(resp_cyc_b - c), 64'd10);
        tick(2);

        // 6: asynchronous reset during write-back
        rr_a = 1'b0;
        n = resp_cnt_a;
        start_miss(1'b0, 32'h0000_5000, 1'b1, 32'h0000_6000, 32'h1234_5678);
        tick(1);
        check("wb_valid_pre_rst", 64'(rv_a), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_valid", 64'(rv_a), 64'd0);
        check("arst_we", 64'(we_a), 64'd0);
        check("arst_addr", 64'(ra_a), 64'd0);
        check("arst_wdata", 64'(wd_a), 64'd0);
        check("arst_busy", 64'(busy_a), 64'd0);
        check("arst_line", 64'(line_a), 64'd0);
        check("arst_resp", 64'(resp_a), 64'd0);
        tick(2);
        rr_a = 1'b1;
        rst = 1'b1;
        tick(4);
        check("no_resp_after_rst", 64'(resp_cnt_a - n), 64'd0);
        exp_cmd_a.push_back('{1'b0, 32'h0000_7000, 32'h0});
        rd_a.push_back(32'h0F0F_0F0F);
        exp_line_a.push_back(32'h0F0F_0F0F);
        c = cyc;
        start_miss(1'b0, 32'h0000_703F, 1'b0, 32'h0, 32'h0);
        wait_resp(1'b0, 20);
        check("lat_after_rst", 64'(resp_cyc_a - c), 64'd3);
        tick(3);

        check("cmd_q_empty_a", 64'(exp_cmd_a.size()), 64'd0);
        check("line_q_empty_a", 64'(exp_line_a.size()), 64'd0);
        check("cmd_q_empty_b", 64'(exp_cmd_b.size()), 64'd0);
        check("line_q_empty_b", 64'(exp_line_b.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_refill_ctrl.md
Name: mem_refill_ctrl

Overview:
Miss handler between sa_cache and the backing memory. It consumes cache_miss plus the eviction outputs of sa_cache (o_evict, o_evict_addr, o_evict_data). It then runs a write-back of the victim line followed by a line fill over a valid/ready memory bus. Finally it returns the filled line to sa_cache through i_memory_line and i_memory_response.

Parameters:
LINE_W, 32, cache line width in bits; must equal the sa_cache line_data width.
BUS_W, 32, memory bus data width; LINE_W must be an integer multiple of BUS_W.
ADDR_W, 32, address width ({tag[17:0], index[7:0], offset[5:0]}).
OFFS_W, 6, offset bits cleared to form the line-aligned address.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
cache_miss  in  1  level from sa_cache, high while a miss is outstanding
miss_addr  in  ADDR_W  {i_tag, i_index, i_offset} of the missing access
evict  in  1  from sa_cache o_evict: the victim line is dirty
evict_addr  in  ADDR_W  from o_evict_addr
evict_data  in  LINE_W  from o_evict_data
o_memory_line  out  LINE_W  filled line, drives sa_cache i_memory_line
o_memory_response  out  1  one-cycle fill-done pulse, drives i_memory_response
busy  out  1  high in every state except IDLE
mem_req_valid  out  1  memory command valid
mem_req_ready  in  1  memory command accepted
mem_req_we  out  1  1 = write beat, 0 = line read
mem_req_addr  out  ADDR_W  command address
mem_req_wdata  out  BUS_W  write beat data
mem_rsp_valid  in  1  read beat valid (no backpressure)
mem_rsp_data  in  BUS_W  read beat data

Behaviour:
- BEATS = LINE_W/BUS_W. Beat byte stride = BUS_W/8. Line-aligned address = addr with [OFFS_W-1:0] cleared.
- Reset (rst low, async): state IDLE, beat counter 0. Every output is 0, including o_memory_line. Reset mid-operation abandons the transaction; no response pulse is issued.
- FSM states: IDLE, WB, FILL_REQ, FILL_DATA, RESP, HOLD.
- IDLE:
  - On a clk edge with cache_miss=1, capture the line-aligned miss_addr, evict, the line-aligned evict_addr and evict_data.
  - Next state is WB if evict=1, else FILL_REQ.
- WB:
  - Drive mem_req_valid=1, we=1, addr = evict_base + k*stride, wdata = evict_data[k*BUS_W +: BUS_W], for k = 0..BEATS-1.
  - k advances only on valid&&ready.
  - After the last beat is accepted, go to FILL_REQ. Valid stays high (no bubble) between beats.
- FILL_REQ:
  - Drive valid=1, we=0, addr = miss_base, wdata=0.
  - On ready, go to FILL_DATA with the beat counter set to 0.
  - Valid, addr and we stay stable while ready=0.
- FILL_DATA:
  - Each mem_rsp_valid writes mem_rsp_data into o_memory_line[k*BUS_W +: BUS_W] and increments k.
  - After beat BEATS-1, go to RESP.
  - mem_rsp_valid in any other state is ignored.
- RESP: o_memory_response=1 for exactly one cycle; next state HOLD.
- HOLD: one cycle that ignores cache_miss, giving sa_cache time to install the line and drop its miss; then IDLE.
- o_memory_line holds its value from RESP until the next FILL_DATA beat overwrites it.
- mem_req_valid is 0 in IDLE, FILL_DATA, RESP and HOLD. In those states mem_req_we, mem_req_addr and mem_req_wdata are 0.
- Inputs miss_addr, evict, evict_addr and evict_data are sampled only at acceptance; later changes have no effect.
- Best-case latency, no evict, ready and rsp immediate, BEATS=1:
  - Miss sampled at edge 0.
  - Command issued in cycle 1 and accepted at edge 1.
  - Response beat in cycle 2, captured at edge 2.
  - o_memory_response high in cycle 3.
- With evict, add BEATS cycles of write-back ahead of the fill.

Test Plan:
1. Clean miss, BEATS=1: miss_addr=0x0000_0044, evict=0, ready=1, rsp_data=0xDEADBEEF one cycle after the command → one read at 0x0000_0040, we=0. o_memory_response pulses one cycle, o_memory_line=0xDEADBEEF, no write commands.
2. Dirty miss: miss_addr=0x0000_1000, evict=1, evict_addr=0x0004_0010, evict_data=0xCAFEF00D → write at 0x0004_0000 with wdata 0xCAFEF00D, then read at 0x0000_1000. The response pulse arrives one cycle later than in scenario 1.
3. Backpressure: ready held 0 for 5 cycles during FILL_REQ → valid, addr and we stay stable all 5 cycles; exactly one command is accepted; busy stays 1 throughout.
4. BUS_W=8 (BEATS=4), dirty miss with evict_data=0x44332211 → writes 0x11,0x22,0x33,0x44 to base+0..3. Read beats 0xA1,0xB2,0xC3,0xD4 → o_memory_line=0xD4C3B2A1.
5. cache_miss kept high after the response → no new request during HOLD; a second miss is accepted at the first IDLE edge after it. A stray mem_rsp_valid in IDLE leaves o_memory_line unchanged.
6. rst driven low mid-WB, asynchronously between edges → all outputs 0 immediately and no response pulse. After release, a new miss completes normally.
